// File: rtl/dma_pkg.sv
// Shared types for the DMA request/priority block: arbiter state encoding and channel-count ceiling.
package dma_pkg;

  localparam int DMA_MAX_CH = 8;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_REQ,
    ARB_GRANT,
    ARB_RELEASE
  } dma_arb_state_e;

endpackage

// File: rtl/dma_prio_encoder.sv
// Combinational cyclic priority encoder: channel lowest_ch_i+1 wins first, lowest_ch_i wins last.
// Zero latency, no flow control; winner_o is meaningful only while any_req_o is high.
module dma_prio_encoder #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [CH_W-1:0]   lowest_ch_i,
  output logic [CH_W-1:0]   winner_o,
  output logic              any_req_o
);

  logic [2*NUM_CH-1:0] dbl;
  logic [NUM_CH-1:0]   rot;
  logic                found;
  int                  start;
  int                  off;

  // Rotate so the highest-priority channel lands on bit 0, find-first, then undo the rotation.
  always_comb begin
    start = (int'(lowest_ch_i) + 1) % NUM_CH;
    dbl   = {req_i, req_i};
    rot   = dbl[start +: NUM_CH];
    found = 1'b0;
    off   = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        off   = i;
      end
    end
    winner_o  = CH_W'((start + off) % NUM_CH);
    any_req_o = |req_i;
  end

endmodule

// File: rtl/dma_channel_arbiter.sv
// 8237-style DREQ conditioning, fixed/rotating arbitration and HRQ/HLDA handshake for NUM_CH channels.
// hrq rises two edges after DREQ, DACK one edge after HLDA; optional software requests via DMA_ARB_SW_REQ_EN.
module dma_channel_arbiter
  import dma_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [NUM_CH-1:0] dreq,
  input  logic              dreqActiveLow,
  input  logic              dackActiveLow,
  input  logic              rotatePriority,
  input  logic [NUM_CH-1:0] chMask,
  input  logic              hlda,
  input  logic              xferDone,
  input  logic              tc,
  input  logic              swReqWr,
  input  logic [CH_W-1:0]   swReqCh,
  input  logic              swReqSet,
  output logic              hrq,
  output logic [NUM_CH-1:0] dack,
  output logic              validDack,
  output logic [CH_W-1:0]   grantCh,
  output logic [CH_W-1:0]   lowestCh
);

  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);
  localparam logic [CH_W:0]   CH_CNT  = (CH_W + 1)'(NUM_CH);

  dma_arb_state_e    state_q;
  logic              hrq_q;
  logic              valid_q;
  logic [CH_W-1:0]   grant_q;
  logic [CH_W-1:0]   lowest_q;
  logic [NUM_CH-1:0] dreq_q;
  logic [NUM_CH-1:0] sw_req;
  logic [NUM_CH-1:0] req;
  logic [NUM_CH-1:0] dack_act;
  logic [CH_W-1:0]   winner;
  logic              any_req;

  always_ff @(posedge CLK) begin
    if (RESET) dreq_q <= '0;
    else       dreq_q <= dreq ^ {NUM_CH{dreqActiveLow}};
  end

`ifdef DMA_ARB_SW_REQ_EN
  logic [NUM_CH-1:0] swreq_q;
  logic [NUM_CH-1:0] swreq_d;

  // A register write is applied after the terminal-count clear so a same-cycle set survives.
  always_comb begin
    swreq_d = swreq_q;
    if (xferDone && tc) swreq_d[grant_q] = 1'b0;
    if (swReqWr && ({1'b0, swReqCh} < CH_CNT)) swreq_d[swReqCh] = swReqSet;
  end

  always_ff @(posedge CLK) begin
    if (RESET) swreq_q <= '0;
    else       swreq_q <= swreq_d;
  end

  assign sw_req = swreq_q;
`else
  logic unused_sw;
  assign unused_sw = ^{swReqWr, swReqCh, swReqSet, tc, CH_CNT};
  assign sw_req    = '0;
`endif

  assign req = (dreq_q & ~chMask) | sw_req;

  dma_prio_encoder #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_prio (
    .req_i       (req),
    .lowest_ch_i (lowest_q),
    .winner_o    (winner),
    .any_req_o   (any_req)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= ARB_IDLE;
      hrq_q    <= 1'b0;
      valid_q  <= 1'b0;
      grant_q  <= '0;
      lowest_q <= LAST_CH;
    end else begin
      if (!rotatePriority) lowest_q <= LAST_CH;
      case (state_q)
        ARB_IDLE: begin
          if (any_req) begin
            state_q <= ARB_REQ;
            hrq_q   <= 1'b1;
          end
        end
        ARB_REQ: begin
          if (hlda && any_req) begin
            state_q <= ARB_GRANT;
            grant_q <= winner;
            valid_q <= 1'b1;
          end else if (!any_req) begin
            state_q <= hlda ? ARB_RELEASE : ARB_IDLE;
            hrq_q   <= 1'b0;
          end
        end
        ARB_GRANT: begin
          // The grant is held through request drop or masking; only completion or loss of HLDA ends it.
          if (xferDone) begin
            state_q <= ARB_RELEASE;
            hrq_q   <= 1'b0;
            valid_q <= 1'b0;
            if (rotatePriority) lowest_q <= grant_q;
          end else if (!hlda) begin
            state_q <= ARB_RELEASE;
            hrq_q   <= 1'b0;
            valid_q <= 1'b0;
          end
        end
        ARB_RELEASE: begin
          if (!hlda) state_q <= ARB_IDLE;
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  always_comb begin
    dack_act          = '0;
    dack_act[grant_q] = valid_q;
  end

  assign dack      = dack_act ^ {NUM_CH{dackActiveLow}};
  assign hrq       = hrq_q;
  assign validDack = valid_q;
  assign grantCh   = grant_q;
  assign lowestCh  = lowest_q;

endmodule

// File: tb/tb_dma_channel_arbiter.sv
// Directed scoreboard bench for dma_channel_arbiter (NUM_CH=4); expected grants queued as DREQ is driven.
module tb_dma_channel_arbiter;

  logic       clk = 1'b0;
  logic       RESET = 1'b0;
  logic [3:0] dreq = '0;
  logic       dreqActiveLow = 1'b0;
  logic       dackActiveLow = 1'b0;
  logic       rotatePriority = 1'b0;
  logic [3:0] chMask = '0;
  logic       hlda = 1'b0;
  logic       xferDone = 1'b0;
  logic       tc = 1'b0;
  logic       swReqWr = 1'b0;
  logic [1:0] swReqCh = '0;
  logic       swReqSet = 1'b0;
  logic       hrq;
  logic [3:0] dack;
  logic       validDack;
  logic [1:0] grantCh;
  logic [1:0] lowestCh;

  typedef struct {
    int         ch;
    logic [3:0] dack;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  dma_channel_arbiter #(.NUM_CH(4)) dut (
    .CLK            (clk),
    .RESET          (RESET),
    .dreq           (dreq),
    .dreqActiveLow  (dreqActiveLow),
    .dackActiveLow  (dackActiveLow),
    .rotatePriority (rotatePriority),
    .chMask         (chMask),
    .hlda           (hlda),
    .xferDone       (xferDone),
    .tc             (tc),
    .swReqWr        (swReqWr),
    .swReqCh        (swReqCh),
    .swReqSet       (swReqSet),
    .hrq            (hrq),
    .dack           (dack),
    .validDack      (validDack),
    .grantCh        (grantCh),
    .lowestCh       (lowestCh)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    tick();
    tick();
    RESET = 1'b0;
  endtask

  task automatic push_exp(input int ch, input logic [3:0] d);
    exp_t e;
    e.ch   = ch;
    e.dack = d;
    sb.push_back(e);
  endtask

  // Wait for hrq, answer with hlda, then compare the resulting grant with the head of the scoreboard.
  task automatic serve_grant(input string tag);
    exp_t e;
    int   n;
    n = 0;
    while (!hrq && n < 20) begin tick(); n++; end
    check({tag, "_hrq"}, 32'(hrq), 32'd1);
    hlda = 1'b1;
    tick();
    n = 0;
    while (!validDack && n < 20) begin tick(); n++; end
    check({tag, "_vld"}, 32'(validDack), 32'd1);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check({tag, "_grant"}, 32'(grantCh), 32'(e.ch));
      check({tag, "_dack"}, 32'(dack), 32'(e.dack));
    end
  endtask

  task automatic serve_done(input string tag, input logic tc_val);
    xferDone = 1'b1;
    tc       = tc_val;
    tick();
    xferDone = 1'b0;
    tc       = 1'b0;
    check({tag, "_rel_hrq"}, 32'(hrq), 32'd0);
    check({tag, "_rel_vld"}, 32'(validDack), 32'd0);
    hlda = 1'b0;
    tick();
  endtask

  initial begin
    // Reset state
    do_reset();
    check("rst_hrq", 32'(hrq), 32'd0);
    check("rst_vld", 32'(validDack), 32'd0);
    check("rst_grant", 32'(grantCh), 32'd0);
    check("rst_lowest", 32'(lowestCh), 32'd3);
    check("rst_dack", 32'(dack), 32'h0);

    // 1: fixed priority, active-high, latency then re-request of ch3
    dreq = 4'b1010;
    push_exp(1, 4'b0010);
    tick();
    check("t1_lat_k", 32'(hrq), 32'd0);
    tick();
    check("t1_lat_k1", 32'(hrq), 32'd1);
    serve_grant("t1a");
    dreq = 4'b1000;
    push_exp(3, 4'b1000);
    serve_done("t1a", 1'b0);
    check("t1_idle_dack", 32'(dack), 32'h0);
    serve_grant("t1b");
    serve_done("t1b", 1'b0);

    // 2: rotating priority, all channels requesting
    do_reset();
    rotatePriority = 1'b1;
    dreq = 4'b1111;
    for (int i = 0; i < 5; i++) push_exp(i % 4, 4'(1 << (i % 4)));
    for (int i = 0; i < 5; i++) begin
      serve_grant("t2");
      serve_done("t2", 1'b0);
      check("t2_lowest", 32'(lowestCh), 32'(i % 4));
    end
    rotatePriority = 1'b0;
    tick();
    check("t2_fixed_lowest", 32'(lowestCh), 32'd3);

    // 3: active-low DREQ and DACK
    dreq = 4'b1111;
    dreqActiveLow = 1'b1;
    dackActiveLow = 1'b1;
    do_reset();
    check("t3_idle_dack", 32'(dack), 32'hF);
    dreq = 4'b1011;
    push_exp(2, 4'b1011);
    serve_grant("t3");
    serve_done("t3", 1'b0);
    check("t3_rel_dack", 32'(dack), 32'hF);
    dreq = 4'b0000;
    dreqActiveLow = 1'b0;
    dackActiveLow = 1'b0;

    // 4: masking blocks new requests but never an active grant
    do_reset();
    chMask = 4'b0001;
    dreq   = 4'b0001;
    repeat (4) tick();
    check("t4_masked_hrq", 32'(hrq), 32'd0);
    chMask = 4'b0000;
    push_exp(0, 4'b0001);
    serve_grant("t4");
    chMask = 4'b0001;
    dreq   = 4'b0000;
    repeat (3) tick();
    check("t4_hold_vld", 32'(validDack), 32'd1);
    check("t4_hold_dack", 32'(dack), 32'h1);
    serve_done("t4", 1'b0);
    check("t4_done_dack", 32'(dack), 32'h0);
    chMask = 4'b0000;

    // 5: HLDA preemption leaves lowestCh alone; reset during grant
    do_reset();
    rotatePriority = 1'b1;
    dreq = 4'b0100;
    push_exp(2, 4'b0100);
    serve_grant("t5a");
    dreq = 4'b0010;
    push_exp(1, 4'b0010);
    serve_done("t5a", 1'b0);
    check("t5_lowest_rot", 32'(lowestCh), 32'd2);
    serve_grant("t5b");
    hlda = 1'b0;
    tick();
    check("t5_pre_dack", 32'(dack), 32'h0);
    check("t5_pre_hrq", 32'(hrq), 32'd0);
    check("t5_pre_lowest", 32'(lowestCh), 32'd2);
    push_exp(1, 4'b0010);
    serve_grant("t5c");
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    hlda  = 1'b0;
    dreq  = 4'b0000;
    check("t5_rst_hrq", 32'(hrq), 32'd0);
    check("t5_rst_vld", 32'(validDack), 32'd0);
    check("t5_rst_grant", 32'(grantCh), 32'd0);
    check("t5_rst_lowest", 32'(lowestCh), 32'd3);
    check("t5_rst_dack", 32'(dack), 32'h0);
    rotatePriority = 1'b0;
    do_reset();

    // 6: software requests bypass the mask
    chMask   = 4'b1111;
    swReqWr  = 1'b1;
    swReqCh  = 2'd2;
    swReqSet = 1'b1;
    tick();
    swReqWr = 1'b0;
`ifdef DMA_ARB_SW_REQ_EN
    push_exp(2, 4'b0100);
    serve_grant("t6a");
    serve_done("t6a", 1'b1);
    repeat (3) tick();
    check("t6_tc_clear_hrq", 32'(hrq), 32'd0);
    swReqWr = 1'b1;
    tick();
    swReqWr = 1'b0;
    push_exp(2, 4'b0100);
    push_exp(2, 4'b0100);
    serve_grant("t6b");
    swReqWr = 1'b1;
    serve_done("t6b", 1'b1);
    swReqWr = 1'b0;
    serve_grant("t6c");
    swReqWr  = 1'b1;
    swReqSet = 1'b0;
    tick();
    swReqWr = 1'b0;
    serve_done("t6c", 1'b0);
    repeat (3) tick();
    check("t6_wr_clear_hrq", 32'(hrq), 32'd0);
`else
    repeat (4) tick();
    check("t6_sw_ignored_hrq", 32'(hrq), 32'd0);
`endif
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
